// File: rtl/tm_warp_launcher.sv
// Thread-manager warp launcher: queues launch requests, claims a free hardware
// slot, runs the RAU allocation handshake and announces started warps to IB.
module tm_warp_launcher #(
  parameter int NUM_HW  = 8,
  parameter int SWID_W  = 8,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 32,
  localparam int HWID_W = $clog2(NUM_HW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Launch_Valid_CTA_TM,
  output logic              Launch_Ready_TM_CTA,
  input  logic [SWID_W-1:0] Launch_SWWarp_CTA_TM,
  input  logic [2:0]        Launch_Nreq_CTA_TM,
  input  logic [4:0]        Available_RAU_TM,
  input  logic              Req_Done_RAU_IB,
  input  logic              ExitEN_IB_RAU,
  input  logic [HWID_W-1:0] ExitWarpID_IB_RAU,
  output logic              AlloEN_TM_RAU,
  output logic [2:0]        Nreq_TM_RAU,
  output logic [HWID_W-1:0] HWWarp_TM_RAU,
  output logic [SWID_W-1:0] SWWarp_TM_RAU,
  output logic              WarpStart_TM_IB,
  output logic [HWID_W-1:0] WarpStartID_TM_IB,
  output logic [NUM_HW-1:0] WarpActive_TM_IB,
  output logic              AllocErr_TM
);

  localparam int AW    = $clog2(QDEPTH);
  localparam int EW    = SWID_W + 3;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT1 = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [QDEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [NUM_HW-1:0] active_q, active_d;
  logic [2:0]        nreq_q, nreq_d;
  logic [HWID_W-1:0] hw_q, hw_d;
  logic [SWID_W-1:0] sw_q, sw_d;

  logic              push, pop;
  logic [SWID_W-1:0] head_sw;
  logic [2:0]        head_nreq;
  logic [3:0]        need;
  logic              free_found;
  logic [HWID_W-1:0] free_idx;
  logic              launch_ok;
  logic              warp_start;
  logic [NUM_HW-1:0] set_mask, clr_mask;

  // Launch handshake: a request transfers on a rising edge where valid and
  // ready are both high; ready is registered and already reflects the pop/push
  // of the previous edge, so it never admits a write into a full queue.
  assign push = Launch_Valid_CTA_TM & ready_q;
  assign pop  = (state_q == S_ISSUE);

  assign head_sw   = mem_q[rd_ptr_q][EW-1:3];
  assign head_nreq = mem_q[rd_ptr_q][2:0];
  // RAU hands out registers in pairs, so odd requests round up.
  assign need      = {1'b0, head_nreq} + {3'b000, head_nreq[0]};

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_HW - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = HWID_W'(i);
      end
    end
  end

  assign launch_ok = (count_q != '0) && free_found &&
                     (Available_RAU_TM >= {1'b0, need}) && !ExitEN_IB_RAU;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != (AW + 1)'(QDEPTH));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    err_d      = err_q;
    nreq_d     = nreq_q;
    hw_d       = hw_q;
    sw_d       = sw_q;
    set_mask   = '0;
    clr_mask   = '0;
    warp_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch_ok) begin
          state_d = S_ISSUE;
          nreq_d  = head_nreq;
          hw_d    = free_idx;
          sw_d    = head_sw;
        end
      end
      S_ISSUE: begin
        set_mask[hw_q] = 1'b1;
        state_d        = S_WAIT1;
      end
      // The done level still belongs to the previous allocation here.
      S_WAIT1: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Req_Done_RAU_IB) begin
          warp_start = 1'b1;
          state_d    = S_GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d          = 1'b1;
          clr_mask[hw_q] = 1'b1;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A slot still mid-allocation cannot exit; it is not live yet.
    if (ExitEN_IB_RAU && active_q[ExitWarpID_IB_RAU] &&
        !(((state_q == S_WAIT1) || (state_q == S_WAIT)) && (ExitWarpID_IB_RAU == hw_q)))
      clr_mask[ExitWarpID_IB_RAU] = 1'b1;
    active_d = (active_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      active_q <= '0;
      nreq_q   <= '0;
      hw_q     <= '0;
      sw_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      active_q <= active_d;
      nreq_q   <= nreq_d;
      hw_q     <= hw_d;
      sw_q     <= sw_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {Launch_SWWarp_CTA_TM, Launch_Nreq_CTA_TM};
  end

  assign Launch_Ready_TM_CTA = ready_q;
  assign AlloEN_TM_RAU       = (state_q == S_ISSUE);
  assign Nreq_TM_RAU         = nreq_q;
  assign HWWarp_TM_RAU       = hw_q;
  assign SWWarp_TM_RAU       = sw_q;
  assign WarpStart_TM_IB     = warp_start;
  assign WarpStartID_TM_IB   = warp_start ? hw_q : '0;
  assign WarpActive_TM_IB    = active_q;
  assign AllocErr_TM         = err_q;

endmodule

// File: tb/tb_tm_warp_launcher.sv
// Bench for tm_warp_launcher: cycle table for the basic launch and resource
// stall, then directed sequences for full slots, exit stall, timeout and reset.
module tb_tm_warp_launcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [7:0] sw_in;
  logic [2:0] nreq_in;
  logic [4:0] avail;
  logic       done;
  logic       exit_en;
  logic [2:0] exit_id;
  logic       allo;
  logic [2:0] nreq_o;
  logic [2:0] hw_o;
  logic [7:0] sw_o;
  logic       start;
  logic [2:0] start_id;
  logic [7:0] active;
  logic       err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tm_warp_launcher dut (
    .clk                  (clk),
    .rst                  (rst),
    .Launch_Valid_CTA_TM  (valid),
    .Launch_Ready_TM_CTA  (ready),
    .Launch_SWWarp_CTA_TM (sw_in),
    .Launch_Nreq_CTA_TM   (nreq_in),
    .Available_RAU_TM     (avail),
    .Req_Done_RAU_IB      (done),
    .ExitEN_IB_RAU        (exit_en),
    .ExitWarpID_IB_RAU    (exit_id),
    .AlloEN_TM_RAU        (allo),
    .Nreq_TM_RAU          (nreq_o),
    .HWWarp_TM_RAU        (hw_o),
    .SWWarp_TM_RAU        (sw_o),
    .WarpStart_TM_IB      (start),
    .WarpStartID_TM_IB    (start_id),
    .WarpActive_TM_IB     (active),
    .AllocErr_TM          (err)
  );

  typedef struct {
    logic       valid;
    logic [7:0] sw;
    logic [2:0] nreq;
    logic [4:0] avail;
    logic       done;
    logic       e_ready;
    logic       e_allo;
    logic [2:0] e_nreq;
    logic [2:0] e_hw;
    logic [7:0] e_sw;
    logic       e_start;
    logic [2:0] e_sid;
    logic [7:0] e_active;
    logic       e_err;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] s, input logic [2:0] n);
    int k;
    @(negedge clk);
    valid = 1'b1; sw_in = s; nreq_in = n;
    #1;
    k = 0;
    while (!ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("push_ready", ready, 1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_allo(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (!allo && k < budget);
    chk("allo_seen", allo, 1);
  endtask

  task automatic finish_ok(input logic [2:0] exp_hw);
    @(negedge clk); done = 1'b0; #1;
    chk("wait1_no_start", start, 0);
    @(negedge clk); done = 1'b1; #1;
    chk("start_pulse", start, 1);
    chk("start_id", start_id, exp_hw);
    @(negedge clk); done = 1'b0; #1;
    chk("gap_no_start", start, 0);
  endtask

  task automatic exit_slot(input logic [2:0] id);
    @(negedge clk); exit_en = 1'b1; exit_id = id; #1;
    @(negedge clk); exit_en = 1'b0; #1;
  endtask

  initial begin
    int n, acc, since, launches;
    logic saw, dn;

    tbl[0]  = '{1'b1, 8'h11, 3'd3, 5'd16, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 3'd0, 5'd16, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 3'd0, 5'd16, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 3'd0, 5'd16, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 3'd0, 5'd16, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 3'd0, 5'd16, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 3'd0, 5'd16, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 3'd0, 5'd16, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[8]  = '{1'b1, 8'h22, 3'd5, 5'd4,  1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 3'd0, 5'd4,  1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 3'd0, 5'd4,  1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 3'd0, 5'd6,  1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h11, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 3'd0, 5'd6,  1'b0, 1'b1, 1'b1, 3'd5, 3'd1, 8'h22, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 3'd0, 5'd6,  1'b1, 1'b1, 1'b0, 3'd5, 3'd1, 8'h22, 1'b0, 3'd0, 8'h03, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 3'd0, 5'd6,  1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 8'h22, 1'b0, 3'd0, 8'h03, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 3'd0, 5'd6,  1'b1, 1'b1, 1'b0, 3'd5, 3'd1, 8'h22, 1'b1, 3'd1, 8'h03, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 3'd0, 5'd6,  1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 8'h22, 1'b0, 3'd0, 8'h03, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 3'd0, 5'd6,  1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 8'h22, 1'b0, 3'd0, 8'h03, 1'b0};

    // clock/reset
    rst = 1'b0; valid = 1'b0; sw_in = '0; nreq_in = '0; avail = '0;
    done = 1'b0; exit_en = 1'b0; exit_id = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_allo", allo, 0);
    chk("rst_active", active, 0);
    chk("rst_err", err, 0);
    chk("rst_hw", hw_o, 0);
    rst = 1'b1;

    // basic launch and resource stall, cycle by cycle
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      valid = tbl[i].valid; sw_in = tbl[i].sw; nreq_in = tbl[i].nreq;
      avail = tbl[i].avail; done = tbl[i].done;
      #1;
      chk($sformatf("t%0d_ready", i), ready, tbl[i].e_ready);
      chk($sformatf("t%0d_allo", i), allo, tbl[i].e_allo);
      chk($sformatf("t%0d_nreq", i), nreq_o, tbl[i].e_nreq);
      chk($sformatf("t%0d_hw", i), hw_o, tbl[i].e_hw);
      chk($sformatf("t%0d_sw", i), sw_o, tbl[i].e_sw);
      chk($sformatf("t%0d_start", i), start, tbl[i].e_start);
      chk($sformatf("t%0d_sid", i), start_id, tbl[i].e_sid);
      chk($sformatf("t%0d_active", i), active, tbl[i].e_active);
      chk($sformatf("t%0d_err", i), err, tbl[i].e_err);
    end
    valid = 1'b0; done = 1'b0; avail = 5'd16;

    // fill slots 2..7, then all-busy stall and exit-freed slot reuse
    for (int s = 2; s < 8; s++) begin
      push(8'h30 + 8'(s), 3'd2);
      wait_allo(10);
      chk("fill_hw", hw_o, s);
      finish_ok(3'(s));
    end
    chk("all_active", active, 8'hFF);
    push(8'h55, 3'd2);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (allo) saw = 1'b1;
    end
    chk("full_no_issue", saw, 0);
    exit_slot(3'd5);
    chk("exit5_clears", active, 8'hDF);
    wait_allo(10);
    chk("reuse_hw5", hw_o, 5);
    chk("reuse_sw", sw_o, 8'h55);
    finish_ok(3'd5);

    // exit strobe defers an eligible launch
    @(negedge clk); exit_en = 1'b1; exit_id = 3'd3; #1;
    push(8'h44, 3'd1);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk); exit_en = 1'b1; #1;
      if (allo) saw = 1'b1;
    end
    @(negedge clk); exit_en = 1'b0; #1;
    if (allo) saw = 1'b1;
    chk("exit_defers_allo", saw, 0);
    chk("exit3_cleared", active, 8'hF7);
    @(negedge clk); #1;
    chk("allo_after_exit", allo, 1);
    chk("allo_after_exit_hw", hw_o, 3);
    finish_ok(3'd3);

    // done never arrives: timeout, slot release, exit of allocating slot ignored
    exit_slot(3'd6);
    push(8'h66, 3'd4);
    wait_allo(10);
    chk("to_hw", hw_o, 6);
    n = 0; saw = 1'b0; dn = 1'b0;
    while (n < 40 && !dn) begin
      @(negedge clk); exit_en = (n == 4); exit_id = 3'd6; done = 1'b0; #1;
      n++;
      if (start) saw = 1'b1;
      if (n == 6) chk("exit_of_alloc_ignored", active[6], 1);
      dn = err;
    end
    exit_en = 1'b0;
    chk("timeout_latency", n, 33);
    chk("timeout_err", err, 1);
    chk("timeout_no_start", saw, 0);
    chk("timeout_slot_freed", active, 8'hBF);
    push(8'h77, 3'd0);
    wait_allo(10);
    chk("after_to_hw", hw_o, 6);
    chk("after_to_sw", sw_o, 8'h77);
    finish_ok(3'd6);
    chk("err_sticky", err, 1);

    // five back-to-back requests: queue fills at 4, launches in order
    for (int s = 0; s < 5; s++) exit_slot(3'(s));
    chk("freed_0_4", active, 8'hE0);
    avail = 5'd0; acc = 0;
    repeat (6) begin
      @(negedge clk); valid = 1'b1; sw_in = 8'h60 + 8'(acc); nreq_in = 3'd1; #1;
      if (ready) acc++;
    end
    chk("fifo_accepts_4", acc, 4);
    chk("fifo_full_ready", ready, 0);
    since = 100; launches = 0;
    for (int c = 0; c < 200 && launches < 5; c++) begin
      @(negedge clk);
      valid = (acc < 5); sw_in = 8'h60 + 8'(acc); nreq_in = 3'd1; avail = 5'd16;
      dn = (since == 1); done = dn;
      #1;
      if (dn) begin
        chk("b2b_start", start, 1);
        chk("b2b_start_id", start_id, launches - 1);
      end
      if (valid && ready) acc++;
      if (allo) begin
        chk("b2b_order_sw", sw_o, 8'h60 + 8'(launches));
        chk("b2b_hw", hw_o, launches);
        if (launches > 0) chk("b2b_spacing_ge4", (since + 1) >= 4, 1);
        since = 0;
        launches++;
      end else begin
        since++;
      end
    end
    valid = 1'b0;
    chk("b2b_launches", launches, 5);
    chk("b2b_accepted", acc, 5);
    finish_ok(3'd4);
    chk("b2b_active", active, 8'hFF);

    // reset in the middle of a handshake
    exit_slot(3'd0);
    push(8'h99, 3'd2);
    wait_allo(10);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_allo", allo, 0);
    chk("mid_rst_nreq", nreq_o, 0);
    chk("mid_rst_hw", hw_o, 0);
    chk("mid_rst_sw", sw_o, 0);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_sid", start_id, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", ready, 1);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (allo || start) saw = 1'b1;
    end
    chk("post_rst_queue_lost", saw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
